mc_ctrl: RTL

Multi-cycle main controller for the MIPS datapath: a Moore/Mealy FSM that sequences each instruction through FETCH, DECODE, EXE, MEM and WB. It drives the PC/IR write enables, the immediate-extension mode (`ext_op`) for the extender, and the ALU, register-file and data-memory controls. It waits on a data-memory acknowledge handshake and flags unsupported opcodes. It sits between the IR (opcode/funct source) and every datapath mux and enable.

---
 rtl/mc_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller sequencing FETCH/DECODE/EXE/MEM/WB
// and driving every datapath enable and mux select from op/funct.
module mc_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ack,
   output logic       pc_wr,
   output logic       ir_wr,
   output logic [1:0] npc_sel,
   output logic       ext_op,
   output logic [1:0] alu_op,
   output logic       alu_src_b,
   output logic       reg_wr,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       instr_done,
   output logic       illegal,
   output logic [2:0] state
);
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXE    = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;
   state_t r_state, w_next;
   logic w_rtype, w_addu, w_subu, w_jr, w_nop, w_ori, w_lui, w_lw, w_sw, w_beq, w_jal, w_legal;
   assign w_rtype = op == 6'b000000;
   assign w_addu  = w_rtype && funct == 6'b100001;
   assign w_subu  = w_rtype && funct == 6'b100011;
   assign w_jr    = w_rtype && funct == 6'b001000;
   assign w_nop   = w_rtype && funct == 6'b000000;
   assign w_ori   = op == 6'b001101;
   assign w_lui   = op == 6'b001111;
   assign w_lw    = op == 6'b100011;
   assign w_sw    = op == 6'b101011;
   assign w_beq   = op == 6'b000100;
   assign w_jal   = op == 6'b000011;
   assign w_legal = w_addu | w_subu | w_jr | w_nop | w_ori | w_lui | w_lw | w_sw | w_beq | w_jal;
   always_ff @(posedge clk) begin
      if (reset) r_state <= FETCH;
      else       r_state <= w_next;
   end
   always_comb begin
      w_next     = FETCH;
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      npc_sel    = 2'd0;
      reg_wr     = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      ext_op     = w_lw | w_sw | w_beq;
      alu_op     = (w_subu | w_beq) ? 2'd1 : w_ori ? 2'd2 : w_lui ? 2'd3 : 2'd0;
      alu_src_b  = w_ori | w_lui | w_lw | w_sw;
      reg_dst    = (w_addu | w_subu) ? 2'd1 : w_jal ? 2'd2 : 2'd0;
      mem_to_reg = w_lw ? 2'd1 : w_jal ? 2'd2 : 2'd0;
      state      = r_state;
      case (r_state)
         FETCH: begin
            ir_wr  = 1'b1;
            pc_wr  = 1'b1;
            w_next = DECODE;
         end
         DECODE: begin
            if (w_jal) begin
               reg_wr     = 1'b1;
               pc_wr      = 1'b1;
               npc_sel    = 2'd2;
               instr_done = 1'b1;
            end else if (w_jr) begin
               pc_wr      = 1'b1;
               npc_sel    = 2'd3;
               instr_done = 1'b1;
            end else if (w_nop) begin
               instr_done = 1'b1;
            end else if (!w_legal) begin
               illegal    = 1'b1;
               instr_done = 1'b1;
            end else begin
               w_next = EXE;
            end
         end
         EXE: begin
            if (w_beq) begin
               pc_wr      = zero;
               npc_sel    = 2'd1;
               instr_done = 1'b1;
            end else begin
               w_next = (w_lw | w_sw) ? MEM : WB;
            end
         end
         MEM: begin
            mem_rd     = w_lw;
            mem_wr     = w_sw;
            instr_done = mem_ack & w_sw;
            w_next     = !mem_ack ? MEM : w_lw ? WB : FETCH;
         end
         WB: begin
            reg_wr     = 1'b1;
            instr_done = 1'b1;
         end
         default: begin
            w_next = FETCH;
         end
      endcase
      // Reset wins over everything, including an access still pending in MEM.
      if (reset) begin
         pc_wr      = 1'b0;
         ir_wr      = 1'b0;
         npc_sel    = 2'd0;
         reg_wr     = 1'b0;
         mem_rd     = 1'b0;
         mem_wr     = 1'b0;
         instr_done = 1'b0;
         illegal    = 1'b0;
         ext_op     = 1'b0;
         alu_op     = 2'd0;
         alu_src_b  = 1'b0;
         reg_dst    = 2'd0;
         mem_to_reg = 2'd0;
         state      = 3'd0;
      end
   end
endmodule
